bcd_sub_serial: RTL and testbench
=================================

# bcd_sub_serial

Digit-serial multi-digit BCD subtractor. Computes A − B − bin on packed BCD operands, one decimal digit per clock, least-significant digit first, with a start/busy/done handshake. It is the subtracting counterpart of the team's combinational BCD adder and feeds the same decimal datapath. A negative result is presented in ten's complement, or optionally as sign-magnitude.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits per operand (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  4*DIGITS  minuend; packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS  subtrahend; packed BCD.
- bin  in  1  borrow in.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when results update.
- diff  out  4*DIGITS  result digits.
- bout  out  1  final borrow; 1 means A < B + bin.
- err  out  1  at least one operand digit was > 9.

## Operation
- States: IDLE → RUN → (NEG, only if macro enabled) → IDLE.
- IDLE, start=1:
  - Latch a, b, bin.
  - Digit counter = 0; busy=1; go to RUN.
  - err_next = OR over all 2*DIGITS input digits of (digit > 9).
- RUN, one digit per cycle at counter i:
  - t = a_i − b_i − borrow, computed in 5-bit signed.
  - If t < 0: digit = t + 10, borrow = 1; else digit = t, borrow = 0.
  - Store the low 4 bits of digit in position i; counter increments.
  - After digit DIGITS−1, the final borrow becomes bout.
- Invalid digits (>9) are not blocked. They follow the same formula, and the result digit is the low 4 bits. err flags the operation.
- diff, bout and err are output registers. They update only on the done cycle and hold stable until the next done.
- start asserted while busy=1 is ignored; it is not queued.
- Input changes after the start cycle have no effect.
- Counter range is 0..DIGITS−1, with no wrap-around beyond the last digit.
- Reset, including mid-operation: state = IDLE; busy=0; done=0; diff=0; bout=0; err=0; internal registers cleared. The partial result is discarded.

## Timing
- Start sampled high at edge E0; busy=1 after E0.
- Digit i is processed at edge E(i+1).
- After edge E(DIGITS), with macro disabled or bout=0:
  - diff, bout and err are valid.
  - done=1 for exactly one cycle.
  - busy=0 in the same cycle as done.
- Latency is DIGITS cycles, start edge to done.
- A new start may be sampled in the done cycle. It is accepted at the next edge, so throughput is one operation per DIGITS+1 cycles.
- With the macro enabled and bout=1: NEG adds DIGITS cycles, for a total latency of 2*DIGITS. bout is still the sign.

## Configuration
- BCD_SUB_SIGN_MAG_EN undefined:
  - A negative result is left as ten's complement, diff = A − B − bin + 10^DIGITS.
  - The NEG state is not synthesized.
- BCD_SUB_SIGN_MAG_EN defined, when the final borrow is 1:
  - The FSM enters NEG and serially computes 0 − diff (same digit rule, borrow-in 0), one digit per cycle, digit 0 first.
  - diff then holds the magnitude and bout=1 is the sign.
  - done asserts after the last NEG digit.
  - Results with bout=0 are unaffected.

## Test plan
All cases use DIGITS=4.
- a=0x5000, b=0x1234, bin=0, start for 1 cycle:
  - done exactly 4 cycles later; diff=0x3766, bout=0, err=0.
  - busy high for 4 cycles.
- a=0x0000, b=0x0001, bin=0:
  - Macro off: diff=0x9999, bout=1 at 4 cycles.
  - Macro on: diff=0x0001, bout=1 at 8 cycles.
- a=0x9999, b=0x9999, bin=1:
  - Macro off: diff=0x9999, bout=1.
  - Macro on: diff=0x0001, bout=1.
- a=0x00A0, b=0x0000: err=1 on done. A following valid operation (0x0010 − 0x0005) gives err=0, diff=0x0005.
- start held high continuously with a=0x0042, b=0x0002:
  - Done pulses every 5 cycles, each with diff=0x0040.
  - Operand changes during busy do not alter the in-flight result.
- rst_n low at cycle 2 of an operation: all outputs 0 immediately. After release with no start, busy and done stay 0.

Source files
------------

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: diff = A - B - bin, one digit per clock, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to turn negative results into sign-magnitude (extra NEG pass).
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, NEG} state_t;

    state_t          state;
    logic [W-1:0]    a_q, b_q, acc;
    logic            borrow, err_q;
    logic [CW-1:0]   cnt;

    logic [4:0]      t, t_adj;
    logic            neg, last, err_in, go_neg;
    logic [W-1:0]    acc_nx;

    // Operands shift right each cycle so digit 0 of a_q/b_q is always the active digit;
    // result digits enter acc at the top and land in place after DIGITS shifts.
    always_comb begin
        t      = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, borrow};
        neg    = t[4];
        t_adj  = neg ? t + 5'd10 : t;
        acc_nx = (acc >> 4) | (W'(t_adj[3:0]) << (W - 4));
        last   = (cnt == CW'(DIGITS - 1));
`ifdef BCD_SUB_SIGN_MAG_EN
        go_neg = neg;
`else
        go_neg = 1'b0;
`endif
        err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            err_in = err_in | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        err_q  <= err_in;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    acc    <= acc_nx;
                    borrow <= neg;
                    cnt    <= last ? '0 : cnt + 1'b1;
                    if (last && go_neg) begin
                        // Second pass computes 0 - result to recover the magnitude.
                        a_q    <= '0;
                        b_q    <= acc_nx;
                        borrow <= 1'b0;
                        state  <= NEG;
                    end else if (last) begin
                        diff  <= acc_nx;
                        bout  <= neg;
                        err   <= err_q;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef BCD_SUB_SIGN_MAG_EN
                NEG: begin
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    acc    <= acc_nx;
                    borrow <= neg;
                    cnt    <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        diff  <= acc_nx;
                        bout  <= 1'b1;
                        err   <= err_q;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial (DIGITS=4): acceptor pushes model results, monitor checks on done.
// Expectations follow BCD_SUB_SIGN_MAG_EN when it is defined for the build.
module tb_bcd_sub_serial;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, bout, err;
    logic [W-1:0] diff;

    bcd_sub_serial #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         e;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, fails = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digit rule applied literally; only needed when operand digits are not decimal.
    task automatic digit_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                             output logic [W-1:0] d, output logic bo);
        int br = int'(bi);
        d = '0;
        for (int i = 0; i < D; i++) begin
            int t = int'(x[4*i +: 4]) - int'(y[4*i +: 4]) - br;
            if (t < 0) begin t += 10; br = 1; end else br = 0;
            d[4*i +: 4] = 4'(t);
        end
        bo = br[0];
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, output exp_t e);
        bit sm = 0;
`ifdef BCD_SUB_SIGN_MAG_EN
        sm = 1;
`endif
        e.e = 1'b0;
        for (int i = 0; i < D; i++)
            if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) e.e = 1'b1;
        if (!e.e) begin
            longint r = bcd2int(x) - bcd2int(y) - longint'(bi);
            e.bo = (r < 0);
            if (r < 0) r = sm ? -r : r + 10000;
            e.d = int2bcd(r);
        end else begin
            digit_sub(x, y, bi, e.d, e.bo);
            if (sm && e.bo) begin
                logic dummy;
                digit_sub('0, e.d, 1'b0, e.d, dummy);
            end
        end
        e.lat = (sm && e.bo) ? 2 * D : D;
        e.acc_cyc = 0;
    endtask

    // Acceptor: start is taken only while the DUT is idle.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && start && !busy) begin
            model(a, b, bin, e);
            e.acc_cyc = cyc;
            q.push_back(e);
        end
    end

    // Monitor: compare on done, otherwise outputs must hold their last value.
    logic [W-1:0] ref_d = '0;
    logic         ref_bo = 1'b0, ref_e = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            ref_d = '0; ref_bo = 1'b0; ref_e = 1'b0;
        end else if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
                check("err", 32'(err), 32'(e.e));
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                check("busy_on_done", 32'(busy), 32'd0);
                ref_d = e.d; ref_bo = e.bo; ref_e = e.e;
            end
        end else begin
            check("hold", {15'd0, diff, bout}, {15'd0, ref_d, ref_bo});
            check("hold_err", 32'(err), 32'(ref_e));
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        a = x; b = y; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0 || busy) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < D; i++)
            r[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                        : 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        issue(16'h5000, 16'h1234, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        drain();
        issue(16'h0000, 16'h0001, 1'b0); drain();
        issue(16'h9999, 16'h9999, 1'b1); drain();
        issue(16'h00A0, 16'h0000, 1'b0); drain();
        issue(16'h0010, 16'h0005, 1'b0); drain();

        // start held high: back-to-back ops, operands scrambled while busy
        @(negedge clk);
        a = 16'h0042; b = 16'h0002; bin = 1'b0; start = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (busy) begin a = W'($urandom); b = W'($urandom); end
            else begin a = 16'h0042; b = 16'h0002; end
        end
        while (!busy) @(negedge clk);
        start = 1'b0;
        drain();

        // asynchronous reset in the middle of an operation
        issue(16'h5000, 16'h1234, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end

        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] x, y;
            x = rand_bcd();
            y = ($urandom_range(0, 7) == 0) ? x : rand_bcd();
            issue(x, y, 1'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
